fourstate_cmp_arbiter: RTL and testbench

- Shares one four-state comparator between NREQ requesters. Supported operations: case equality (===), case inequality (!==), logical equality (==) and logical inequality (!=).
- Each requester supplies two sized operands. The block extends both to WIDTH, compares them and returns a four-state result tagged with the requester id.
- Sits between expression-evaluation front ends and the shared compare datapath in the Verilog regression models.

---
 rtl/fourstate_cmp_arbiter_if.sv | 35 +++
 rtl/fourstate_cmp_arbiter.sv | 159 +++++++++++++++
 tb/tb_fourstate_cmp_arbiter.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fourstate_cmp_arbiter_if.sv
// Request/response bus between NREQ expression front ends and the shared four-state comparator.
interface fourstate_cmp_arbiter_if #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LW    = 4,
  parameter int unsigned IDW   = 2
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [2*NREQ-1:0]     req_op;
  logic [NREQ-1:0]       req_signed;
  logic [NREQ*WIDTH-1:0] req_a_val;
  logic [NREQ*WIDTH-1:0] req_a_xz;
  logic [NREQ*WIDTH-1:0] req_b_val;
  logic [NREQ*WIDTH-1:0] req_b_xz;
  logic [NREQ*LW-1:0]    req_a_len;
  logic [NREQ*LW-1:0]    req_b_len;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic                  rsp_val;
  logic                  rsp_xz;

  modport master (
    output req_valid, req_op, req_signed, req_a_val, req_a_xz, req_b_val, req_b_xz,
           req_a_len, req_b_len, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_val, rsp_xz
  );

  modport slave (
    input  req_valid, req_op, req_signed, req_a_val, req_a_xz, req_b_val, req_b_xz,
           req_a_len, req_b_len, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_val, rsp_xz
  );
endinterface

// File: rtl/fourstate_cmp_arbiter.sv
// Round-robin arbiter sharing one four-state comparator (===, !==, ==, !=) among NREQ requesters.
// Optional macro CMP_STATS_EN adds stat_x, a saturating count of handshaked x/z responses.
module fourstate_cmp_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LW    = 4,
  parameter int unsigned IDW   = 2
) (
  input  logic clk,
  input  logic rst_n,
`ifdef CMP_STATS_EN
  output logic [15:0] stat_x,
`endif
  fourstate_cmp_arbiter_if.slave bus
);

  localparam int unsigned BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_EXT, S_CMP, S_RSP} state_t;

  state_t           r_state;
  logic [IDW-1:0]   r_rr;
  logic [IDW-1:0]   r_id;
  logic [1:0]       r_op;
  logic             r_sgn;
  logic [WIDTH-1:0] r_a_val, r_a_xz, r_b_val, r_b_xz;
  logic [LW-1:0]    r_a_len, r_b_len;
  logic             r_rsp_valid, r_rsp_val, r_rsp_xz;
  logic [IDW-1:0]   r_rsp_id;

  logic [IDW-1:0]   w_gnt;
  logic             w_any;
  logic [NREQ-1:0]  w_ready;
  logic             w_case_eq, w_known_diff, w_any_unk;
  logic             w_res_val, w_res_xz;

  // Extend one plane from its declared length; len 0 acts as 1, oversize clamps to WIDTH.
  function automatic logic [WIDTH-1:0] ext_plane(input logic [WIDTH-1:0] p,
                                                 input logic [LW-1:0]    len,
                                                 input logic             sgn);
    int unsigned      l;
    logic             fill;
    logic [WIDTH-1:0] mask;
    if (len == '0)               l = 1;
    else if (32'(len) > WIDTH)   l = WIDTH;
    else                         l = 32'(len);
    fill = sgn & p[BW'(l - 1)];
    mask = (WIDTH'(1) << l) - WIDTH'(1);
    return (p & mask) | (fill ? ~mask : '0);
  endfunction

  // First valid requester strictly after the rr pointer; nearest candidate is assigned last.
  always_comb begin
    w_any = 1'b0;
    w_gnt = '0;
    for (int k = int'(NREQ); k >= 1; k--) begin
      if (bus.req_valid[IDW'((int'(r_rr) + k) % int'(NREQ))]) begin
        w_any = 1'b1;
        w_gnt = IDW'((int'(r_rr) + k) % int'(NREQ));
      end
    end
  end

  assign w_ready = (rst_n && (r_state == S_IDLE) && w_any) ? (NREQ'(1) << w_gnt) : '0;

  assign w_case_eq    = (r_a_val == r_b_val) && (r_a_xz == r_b_xz);
  assign w_known_diff = |(~r_a_xz & ~r_b_xz & (r_a_val ^ r_b_val));
  assign w_any_unk    = |(r_a_xz | r_b_xz);

  // A known differing bit decides == before any x/z does; op[0] selects the inverted form.
  always_comb begin
    w_res_xz  = 1'b0;
    w_res_val = 1'b0;
    if (!r_op[1])          w_res_val = w_case_eq ^ r_op[0];
    else if (w_known_diff) w_res_val = r_op[0];
    else if (w_any_unk)    w_res_xz  = 1'b1;
    else                   w_res_val = ~r_op[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_rr        <= IDW'(NREQ - 1);
      r_id        <= '0;
      r_op        <= '0;
      r_sgn       <= 1'b0;
      r_a_val     <= '0;
      r_a_xz      <= '0;
      r_b_val     <= '0;
      r_b_xz      <= '0;
      r_a_len     <= '0;
      r_b_len     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_val   <= 1'b0;
      r_rsp_xz    <= 1'b0;
      r_rsp_id    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_id    <= w_gnt;
            r_rr    <= w_gnt;
            r_op    <= bus.req_op[2*w_gnt +: 2];
            r_sgn   <= bus.req_signed[w_gnt];
            r_a_val <= bus.req_a_val[w_gnt*WIDTH +: WIDTH];
            r_a_xz  <= bus.req_a_xz[w_gnt*WIDTH +: WIDTH];
            r_b_val <= bus.req_b_val[w_gnt*WIDTH +: WIDTH];
            r_b_xz  <= bus.req_b_xz[w_gnt*WIDTH +: WIDTH];
            r_a_len <= bus.req_a_len[w_gnt*LW +: LW];
            r_b_len <= bus.req_b_len[w_gnt*LW +: LW];
            r_state <= S_EXT;
          end
        end
        S_EXT: begin
          r_a_val <= ext_plane(r_a_val, r_a_len, r_sgn);
          r_a_xz  <= ext_plane(r_a_xz,  r_a_len, r_sgn);
          r_b_val <= ext_plane(r_b_val, r_b_len, r_sgn);
          r_b_xz  <= ext_plane(r_b_xz,  r_b_len, r_sgn);
          r_state <= S_CMP;
        end
        S_CMP: begin
          r_rsp_val   <= w_res_val;
          r_rsp_xz    <= w_res_xz;
          r_rsp_id    <= r_id;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RSP;
        end
        S_RSP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef CMP_STATS_EN
  logic [15:0] r_stat_x;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_x <= '0;
    end else if (r_rsp_valid && bus.rsp_ready && r_rsp_xz && (r_stat_x != 16'hFFFF)) begin
      r_stat_x <= r_stat_x + 16'd1;
    end
  end

  assign stat_x = r_stat_x;
`endif

  assign bus.req_ready = w_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_val   = r_rsp_val;
  assign bus.rsp_xz    = r_rsp_xz;

endmodule

// File: tb/tb_fourstate_cmp_arbiter.sv
// Bench for fourstate_cmp_arbiter: directed vector table, randomized model checks and
// multi-cycle sequences for backpressure, reset during compare and round-robin fairness.
module tb_fourstate_cmp_arbiter;
  localparam int unsigned NREQ  = 4;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned LW    = 4;
  localparam int unsigned IDW   = 2;
  localparam int          W     = 8;

  typedef struct {
    int idx; int op; int sgn;
    int av; int ax; int al;
    int bv; int bx; int bl;
    int exl; int ev;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fourstate_cmp_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .LW(LW), .IDW(IDW)) bus_if ();

`ifdef CMP_STATS_EN
  logic [15:0] stat_x;
`endif

  fourstate_cmp_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .LW(LW), .IDW(IDW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef CMP_STATS_EN
    .stat_x(stat_x),
`endif
    .bus   (bus_if)
  );

  int n_tests  = 0;
  int n_fail   = 0;
  int exp_stat = 0;
  vec_t vecs[18];

  task automatic check(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: each bit as a symbol 0,1,2(x),3(z); result code = xz*2 + val.
  function automatic int ref_cmp(input int op, input int sgn, input int av, input int ax,
                                 input int al, input int bv, input int bx, input int bl);
    int sa[W];
    int sb[W];
    int la, lb;
    bit same, kd, unk;
    la = (al == 0) ? 1 : ((al > W) ? W : al);
    lb = (bl == 0) ? 1 : ((bl > W) ? W : bl);
    for (int i = 0; i < W; i++) begin
      sa[i] = (i < la) ? (((ax >> i) & 1) * 2 + ((av >> i) & 1)) : ((sgn != 0) ? sa[la-1] : 0);
      sb[i] = (i < lb) ? (((bx >> i) & 1) * 2 + ((bv >> i) & 1)) : ((sgn != 0) ? sb[lb-1] : 0);
    end
    same = 1'b1; kd = 1'b0; unk = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (sa[i] != sb[i]) same = 1'b0;
      if (sa[i] < 2 && sb[i] < 2 && sa[i] != sb[i]) kd = 1'b1;
      if (sa[i] >= 2 || sb[i] >= 2) unk = 1'b1;
    end
    if (op < 2) return (same ? 1 : 0) ^ (op & 1);
    if (kd)     return op & 1;
    if (unk)    return 2;
    return 1 - (op & 1);
  endfunction

  task automatic clear_reqs();
    bus_if.req_valid  = '0;
    bus_if.req_op     = '0;
    bus_if.req_signed = '0;
    bus_if.req_a_val  = '0;
    bus_if.req_a_xz   = '0;
    bus_if.req_b_val  = '0;
    bus_if.req_b_xz   = '0;
    bus_if.req_a_len  = '0;
    bus_if.req_b_len  = '0;
  endtask

  task automatic set_req(input int idx, input int op, input int sgn, input int av, input int ax,
                         input int al, input int bv, input int bx, input int bl);
    logic [NREQ-1:0] m;
    m = NREQ'(1) << idx;
    bus_if.req_valid  = bus_if.req_valid | m;
    bus_if.req_signed = (sgn != 0) ? (bus_if.req_signed | m) : (bus_if.req_signed & ~m);
    bus_if.req_op[idx*2 +: 2]     = 2'(op);
    bus_if.req_a_val[idx*W +: W]  = W'(av);
    bus_if.req_a_xz[idx*W +: W]   = W'(ax);
    bus_if.req_b_val[idx*W +: W]  = W'(bv);
    bus_if.req_b_xz[idx*W +: W]   = W'(bx);
    bus_if.req_a_len[idx*LW +: LW] = LW'(al);
    bus_if.req_b_len[idx*LW +: LW] = LW'(bl);
  endtask

  // Wait (bounded) for a grant to idx on a falling edge; returns in the grant cycle.
  task automatic grant_wait(input int idx, input string nm);
    int n;
    n = 0;
    @(negedge clk); #1;
    while (bus_if.req_ready == '0 && n < 12) begin
      @(negedge clk); #1;
      n++;
    end
    check({nm, "_gnt"}, int'(bus_if.req_ready), 1 << idx);
  endtask

  // Called just after the accept edge; latency counted in falling edges up to rsp_valid.
  task automatic wait_rsp(input string nm, input int eid, input int exl, input int ev);
    int lat;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus_if.rsp_valid && lat < 40);
    check({nm, "_lat"}, lat, 3);
    check({nm, "_id"},  int'(bus_if.rsp_id),  eid);
    check({nm, "_xz"},  int'(bus_if.rsp_xz),  exl);
    check({nm, "_val"}, int'(bus_if.rsp_val), ev);
    if (bus_if.rsp_ready) begin
      @(posedge clk);
      if (exl != 0 && exp_stat < 65535) exp_stat++;
      #1;
      check({nm, "_drop"}, int'(bus_if.rsp_valid), 0);
    end
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    clear_reqs();
    set_req(v.idx, v.op, v.sgn, v.av, v.ax, v.al, v.bv, v.bx, v.bl);
    grant_wait(v.idx, nm);
    @(posedge clk); #1;
    clear_reqs();
    wait_rsp(nm, v.idx, v.exl, v.ev);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    //          idx op sg  av ax al   bv  bx bl  xz val
    vecs[0]  = '{0, 0, 0,  10, 0, 8,  10,   0, 8, 0, 1};
    vecs[1]  = '{0, 0, 0,  10, 0, 8,  20,   0, 8, 0, 0};
    vecs[2]  = '{0, 0, 0,   0, 1, 1,   0,   1, 1, 0, 1};
    vecs[3]  = '{1, 0, 0,   1, 1, 1,   1,   1, 1, 0, 1};
    vecs[4]  = '{1, 0, 0,   0, 1, 1,   1,   1, 1, 0, 0};
    vecs[5]  = '{2, 2, 0,   0, 1, 1,   1,   0, 1, 1, 0};
    vecs[6]  = '{2, 3, 0,   0, 1, 1,   1,   0, 1, 1, 0};
    vecs[7]  = '{3, 0, 0,   1, 0, 1,   1,   0, 2, 0, 1};
    vecs[8]  = '{3, 0, 0,   1, 0, 1,   3,   0, 2, 0, 0};
    vecs[9]  = '{3, 0, 1,   1, 0, 1,   3,   0, 2, 0, 1};
    vecs[10] = '{0, 0, 1,   0, 1, 1,   0, 255, 8, 0, 1};
    vecs[11] = '{1, 1, 0,  10, 0, 8,  20,   0, 8, 0, 1};
    vecs[12] = '{2, 2, 0,   5, 0, 8,   5,   0, 8, 0, 1};
    vecs[13] = '{2, 3, 0,   5, 0, 8,   5,   0, 8, 0, 0};
    vecs[14] = '{0, 0, 0,   3, 0, 0,   1,   0, 1, 0, 1};
    vecs[15] = '{1, 0, 0, 171, 0, 15, 171,  0, 8, 0, 1};
    vecs[16] = '{2, 2, 0,   2, 1, 8,   0,   0, 8, 0, 0};
    vecs[17] = '{3, 3, 0,   2, 1, 8,   0,   0, 8, 0, 1};

    // Reset state, with every requester valid so a leaking grant would show.
    clear_reqs();
    bus_if.rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, 0, 0, i, 0, 8, i, 0, 8);
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready", int'(bus_if.req_ready), 0);
    check("rst_rsp_valid", int'(bus_if.rsp_valid), 0);
    check("rst_rsp_id", int'(bus_if.rsp_id), 0);
    check("rst_rsp_val", int'(bus_if.rsp_val), 0);
    check("rst_rsp_xz", int'(bus_if.rsp_xz), 0);
`ifdef CMP_STATS_EN
    check("rst_stat_x", int'(stat_x), 0);
`endif
    clear_reqs();
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Randomized operands against the symbol-level model.
    for (int i = 0; i < 40; i++) begin
      vec_t v;
      int r;
      v.idx = int'($urandom_range(0, 3));
      v.op  = int'($urandom_range(0, 3));
      v.sgn = int'($urandom_range(0, 1));
      v.av  = int'($urandom_range(0, 255));
      v.ax  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 255) & $urandom_range(0, 255)) : 0;
      v.al  = int'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 0) begin
        v.bv = v.av; v.bx = v.ax;
      end else begin
        v.bv = int'($urandom_range(0, 255));
        v.bx = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 255) & $urandom_range(0, 255)) : 0;
      end
      v.bl  = ($urandom_range(0, 1) == 0) ? v.al : int'($urandom_range(0, 15));
      r     = ref_cmp(v.op, v.sgn, v.av, v.ax, v.al, v.bv, v.bx, v.bl);
      v.exl = r >> 1;
      v.ev  = r & 1;
      run_vec(v, $sformatf("rnd%0d", i));
    end

    // Backpressure: x response held for 5 cycles, req1 waits until after the handshake.
    clear_reqs();
    bus_if.rsp_ready = 1'b0;
    set_req(0, 2, 0, 0, 1, 1, 1, 0, 1);
    grant_wait(0, "bp");
    @(posedge clk); #1;
    clear_reqs();
    set_req(1, 0, 0, 7, 0, 8, 7, 0, 8);
    wait_rsp("bp", 0, 1, 0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("bp_hold%0d_vld", c), int'(bus_if.rsp_valid), 1);
      check($sformatf("bp_hold%0d_id", c),  int'(bus_if.rsp_id), 0);
      check($sformatf("bp_hold%0d_pl", c),  int'({bus_if.rsp_xz, bus_if.rsp_val}), 2);
      check($sformatf("bp_hold%0d_rdy", c), int'(bus_if.req_ready), 0);
    end
    bus_if.rsp_ready = 1'b1;
    @(posedge clk);
    exp_stat++;
    #1;
    check("bp_after_vld", int'(bus_if.rsp_valid), 0);
    check("bp_next_gnt", int'(bus_if.req_ready), 2);
    @(posedge clk); #1;
    clear_reqs();
    wait_rsp("bp2", 1, 0, 1);
`ifdef CMP_STATS_EN
    check("stat_x_count", int'(stat_x), exp_stat);
`endif

    // Reset during CMP drops the in-flight compare; first grant then starts from index 0.
    clear_reqs();
    set_req(0, 0, 0, 5, 0, 8, 5, 0, 8);
    grant_wait(0, "rstc_pre");
    @(posedge clk); #1;
    clear_reqs();
    @(posedge clk); #1;
    set_req(2, 2, 0, 9, 0, 8, 9, 0, 8);
    set_req(3, 0, 0, 1, 0, 8, 2, 0, 8);
    @(negedge clk);
    rst_n = 1'b0;
    exp_stat = 0;
    #1;
    check("rstc_ready", int'(bus_if.req_ready), 0);
    check("rstc_vld", int'(bus_if.rsp_valid), 0);
    check("rstc_pl", int'({bus_if.rsp_id, bus_if.rsp_xz, bus_if.rsp_val}), 0);
`ifdef CMP_STATS_EN
    check("rstc_stat_x", int'(stat_x), 0);
`endif
    repeat (2) @(negedge clk);
    check("rstc_vld_hold", int'(bus_if.rsp_valid), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    grant_wait(2, "rstc_first");
    @(posedge clk); #1;
    clear_reqs();
    wait_rsp("rstc_rsp", 2, 0, 1);

    // Fairness: all four continuously valid after a fresh reset.
    clear_reqs();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, 0, 0, i, 0, 8, i, 0, 8);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int r = 0; r < 6; r++) begin
      grant_wait(r % 4, $sformatf("fair%0d", r));
      @(posedge clk); #1;
      check($sformatf("fair%0d_pulse", r), int'(bus_if.req_ready), 0);
      wait_rsp($sformatf("fair%0d", r), r % 4, 0, 1);
    end
    clear_reqs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
